// File: rtl/sram_arbiter.sv
// Two-master arbiter sharing one SRAM macro: m1 (data, R/W) has fixed priority over m0 (fetch, read-only).
// Define ARB_STARVE_GUARD_EN to build the m0 starvation counter and priority override.
module sram_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  input  logic [3:0]        m1_web,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  typedef enum logic {IDLE, RESP} state_e;

  state_e            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       di_q, di_d;
  logic [3:0]        web_d;
  logic              m0_win, m1_win, force_m0, rd_grant;

  // Address bits outside [ADDR_W+1:2] are deliberately dropped, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr, m1_addr};

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_m0 = m0_req && (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!m0_req || m0_win)
      starve_d = '0;
    else if (starve_q != CNT_W'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
  assign force_m0 = 1'b0;
`endif

  // Grants are gated by rst so nothing reaches the SRAM while reset is asserted.
  assign m1_win = !rst && m1_req && !force_m0;
  assign m0_win = !rst && m0_req && (!m1_req || force_m0);

  assign m0_gnt   = m0_win;
  assign m1_gnt   = m1_win;
  assign sram_cs  = m0_win || m1_win;
  assign rd_grant = m0_win || (m1_win && (m1_web == 4'hF));

  always_comb begin
    a_d   = a_q;
    di_d  = di_q;
    web_d = 4'hF;
    if (m1_win) begin
      a_d   = m1_addr[ADDR_W+1:2];
      di_d  = m1_wdata;
      web_d = m1_web;
    end else if (m0_win) begin
      a_d   = m0_addr[ADDR_W+1:2];
    end
  end

  assign sram_a   = a_d;
  assign sram_di  = di_d;
  assign sram_web = web_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      a_q     <= '0;
      di_q    <= '0;
    end else begin
      a_q  <= a_d;
      di_q <= di_d;
      if (rd_grant) owner_q <= m1_win;
      case (state_q)
        IDLE:    state_q <= rd_grant ? RESP : IDLE;
        RESP:    state_q <= rd_grant ? RESP : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_oe   = (state_q == RESP);
  assign m0_rvalid = (state_q == RESP) && !owner_q;
  assign m1_rvalid = (state_q == RESP) &&  owner_q;
  assign m0_rdata  = sram_do;
  assign m1_rdata  = sram_do;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter that shares one SRAM_wrapper macro between the CPU instruction-fetch port (m0, read-only) and the CPU data port (m1, read/write). Placed in top between CPU and a single unified SRAM_wrapper instance. Replaces the split IM/DM arrangement when a single memory is used. One access is issued per cycle. Read data returns one cycle after the grant. m1 has fixed priority; an optional starvation guard protects m0.

## Interface
- ADDR_W, 14: SRAM word-address width; sram_a = mX_addr[ADDR_W+1:2].
- STARVE_LIMIT, 4: consecutive denied m0 request cycles before m0 is forced to priority (guard only); must be ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  fetch request; m0_addr held stable until granted.
- m0_addr  in  32  fetch byte address.
- m0_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid  out  1  m0_rdata valid this cycle.
- m0_rdata  out  32  read data.
- m1_req  in  1  data request; addr, web and wdata held stable until granted.
- m1_addr  in  32  data byte address.
- m1_web  in  4  active-low byte write enables; 4'hF means read.
- m1_wdata  in  32  write data.
- m1_gnt  out  1  request accepted this cycle (combinational).
- m1_rvalid  out  1  m1_rdata valid this cycle (reads only).
- m1_rdata  out  32  read data.
- sram_cs  out  1  SRAM chip select.
- sram_oe  out  1  SRAM output enable.
- sram_web  out  4  SRAM active-low byte write enables.
- sram_a  out  ADDR_W  SRAM word address.
- sram_di  out  32  SRAM write data.
- sram_do  in  32  SRAM read data.

## Operation
- Arbitration runs every cycle that is not in reset.
  - Winner = m1 if m1_req, else m0 if m0_req.
  - Guard override: if the starvation counter equals STARVE_LIMIT and m0_req is high, m0 wins.
- Winner effects in the same cycle:
  - The winner's gnt is 1.
  - sram_cs = 1.
  - sram_a is taken from the winner's address.
  - For m1: sram_web = m1_web and sram_di = m1_wdata.
  - For m0: sram_web = 4'hF.
- Idle (no winner): sram_cs = 0, sram_web = 4'hF, sram_a and sram_di hold their previous values.
- Address handling: bits [1:0] and bits above ADDR_W+1 are ignored, so addresses alias.
- Response FSM:
  - States: IDLE and RESP (one register), plus a registered owner bit.
  - IDLE→RESP when a read is granted; the owner bit records the granting master.
  - RESP→RESP when another read is granted in the RESP cycle (back-to-back reads).
  - RESP→IDLE otherwise.
- RESP cycle:
  - sram_oe = 1.
  - The owner's rvalid = 1.
  - m0_rdata = m1_rdata = sram_do.
- A granted write completes at the grant edge. Writes never raise rvalid and never leave IDLE by themselves.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when m0_req is high and m0_gnt is low.
  - Clears to 0 when m0_gnt is high or m0_req is low.

## Timing
- Reset values:
  - All gnt = 0 and all rvalid = 0.
  - sram_cs = 0, sram_oe = 0, sram_web = 4'hF.
  - sram_a = 0, sram_di = 0.
  - FSM in IDLE, counter = 0.
- rst is applied asynchronously. gnt and sram_cs are forced to 0 while rst is high.
- Read latency: grant in cycle N, rvalid and data in cycle N+1.
- Write latency: 0 extra cycles after the grant.
- Throughput: one access per cycle, with no bubble between consecutive reads or mixed read/write.
- Simultaneous requests: exactly one gnt per cycle. The loser keeps its request held and is re-arbitrated the next cycle.
- Reset asserted during RESP: the pending rvalid is dropped and the read is lost. Masters must re-request after reset.
- Read followed by a write in the RESP cycle: sram_oe stays 1 for the earlier read; the write is issued in the same cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined: the starvation counter and the m0 override are built. m0 is guaranteed a grant within STARVE_LIMIT+1 cycles of raising m0_req.
- ARB_STARVE_GUARD_EN undefined: no counter logic. Priority is strictly m1 over m0, and m0 can starve indefinitely.

## Test plan
- Reset: assert rst mid-cycle → all outputs at their reset values immediately; sram_web = 4'hF.
- m0 read of 0x0000_0010 (SRAM word 4 = 0xDEADBEEF) → m0_gnt and sram_cs and sram_a = 4 in cycle N; m0_rvalid = 1, sram_oe = 1, m0_rdata = 0xDEADBEEF in N+1.
- m1 byte write of 0x0000_0008, m1_web = 4'b1110, wdata 0x000000AA → sram_web = 4'b1110, sram_a = 2, no rvalid. A subsequent m1 read returns byte0 = 0xAA with the upper bytes unchanged.
- m0_req and m1_req (reads) raised in the same cycle → m1_gnt in cycle N, m1_rvalid in N+1; m0_gnt in N+1, m0_rvalid in N+2 with the correct owner.
- Both requesting continuously, STARVE_LIMIT = 4:
  - With ARB_STARVE_GUARD_EN, m0_gnt in the 5th cycle, then the counter clears.
  - Without the macro, m0_gnt is never asserted.
- Read granted in cycle N, rst pulsed in N+1 → no rvalid, FSM back in IDLE, next grant behaves normally.
